// File: rtl/hyperbus_rx_upsizer_if.sv
// hyperbus_rx_upsizer_if: burst command, PHY read stream and AXI R beat signals of the RX upsizer.
interface hyperbus_rx_upsizer_if #(
  parameter int PhyWidth = 32,
  parameter int AxiDataWidth = 64
);
  localparam int Ratio = AxiDataWidth / PhyWidth;
  localparam int LaneW = Ratio > 1 ? $clog2(Ratio) : 1;
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic [LaneW-1:0] cmd_start_i;
  logic [7:0] cmd_len_i;
  logic rx_valid_i;
  logic rx_ready_o;
  logic [PhyWidth-1:0] rx_data_i;
  logic rx_last_i;
  logic rx_error_i;
  logic r_valid_o;
  logic r_ready_i;
  logic [AxiDataWidth-1:0] r_data_o;
  logic r_last_o;
  logic r_error_o;
  logic overrun_o;
  modport slave (
    input cmd_valid_i, cmd_start_i, cmd_len_i, rx_valid_i, rx_data_i, rx_last_i, rx_error_i, r_ready_i,
    output cmd_ready_o, rx_ready_o, r_valid_o, r_data_o, r_last_o, r_error_o, overrun_o
  );
  modport master (
    output cmd_valid_i, cmd_start_i, cmd_len_i, rx_valid_i, rx_data_i, rx_last_i, rx_error_i, r_ready_i,
    input cmd_ready_o, rx_ready_o, r_valid_o, r_data_o, r_last_o, r_error_o, overrun_o
  );
endinterface

// File: rtl/hyperbus_rx_upsizer.sv
// hyperbus_rx_upsizer: packs PHY read words into AXI R beats with last/error generation.
// Define HYPERBUS_RX_ZERO_FILL_EN to drive unwritten lanes as 0 instead of stale stage data.
module hyperbus_rx_upsizer #(
  parameter int PhyWidth = 32,
  parameter int AxiDataWidth = 64
) (
  input logic clk_i,
  input logic rst_ni,
  hyperbus_rx_upsizer_if.slave bus
);
  localparam int Ratio = AxiDataWidth / PhyWidth;
  localparam int LaneW = Ratio > 1 ? $clog2(Ratio) : 1;
  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;
  state_t state;
  logic [AxiDataWidth-1:0] stage, stage_w;
  logic [LaneW-1:0] lane;
  logic [7:0] beats_left;
  logic err_acc, stage_full, h_last, h_err, h_rxl;
  logic wr, live_done, live_last, live_err, b_last, b_err, b_rxl, load;
  assign bus.rx_ready_o = (state == PACK && !stage_full) || state == DRAIN;
  assign wr = state == PACK && bus.rx_valid_i && !stage_full;
  assign live_done = wr && (lane == LaneW'(Ratio - 1) || bus.rx_last_i);
  assign live_last = beats_left == 8'd0 || bus.rx_last_i;
  assign live_err = err_acc | bus.rx_error_i | (bus.rx_last_i && beats_left != 8'd0);
  // A held (blocked) beat replays its captured last/error once the output frees up
  assign b_last = stage_full ? h_last : live_last;
  assign b_err = stage_full ? h_err : live_err;
  assign b_rxl = stage_full ? h_rxl : bus.rx_last_i;
  assign load = (live_done || stage_full) && (!bus.r_valid_o || bus.r_ready_i);
  always_comb begin
    stage_w = stage;
    if (wr) stage_w[lane*PhyWidth +: PhyWidth] = bus.rx_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      stage <= '0;
      lane <= '0;
      beats_left <= '0;
      err_acc <= 1'b0;
      stage_full <= 1'b0;
      h_last <= 1'b0;
      h_err <= 1'b0;
      h_rxl <= 1'b0;
      bus.cmd_ready_o <= 1'b0;
      bus.r_valid_o <= 1'b0;
      bus.r_data_o <= '0;
      bus.r_last_o <= 1'b0;
      bus.r_error_o <= 1'b0;
      bus.overrun_o <= 1'b0;
    end else begin
      bus.overrun_o <= state == DRAIN && bus.rx_valid_i;
      if (bus.r_ready_i) bus.r_valid_o <= 1'b0;
      if (load) begin
        bus.r_valid_o <= 1'b1;
        bus.r_data_o <= stage_w;
        bus.r_last_o <= b_last;
        bus.r_error_o <= b_err;
        stage_full <= 1'b0;
      end
      case (state)
        IDLE: begin
          bus.cmd_ready_o <= !(bus.cmd_valid_i && bus.cmd_ready_o);
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            state <= PACK;
            lane <= bus.cmd_start_i;
            beats_left <= bus.cmd_len_i;
            err_acc <= 1'b0;
            stage_full <= 1'b0;
`ifdef HYPERBUS_RX_ZERO_FILL_EN
            stage <= '0;
`endif
          end
        end
        PACK: begin
          if (wr) begin
            stage <= stage_w;
            err_acc <= live_done ? 1'b0 : err_acc | bus.rx_error_i;
            lane <= live_done ? '0 : lane + LaneW'(1);
          end
          if (live_done && !load) begin
            stage_full <= 1'b1;
            h_last <= live_last;
            h_err <= live_err;
            h_rxl <= bus.rx_last_i;
          end
          if (load) begin
`ifdef HYPERBUS_RX_ZERO_FILL_EN
            stage <= '0;
`endif
            if (b_last) begin
              state <= b_rxl ? IDLE : DRAIN;
              bus.cmd_ready_o <= b_rxl;
            end else beats_left <= beats_left - 8'd1;
          end
        end
        DRAIN: begin
          if (bus.rx_valid_i && bus.rx_last_i) begin
            state <= IDLE;
            bus.cmd_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperbus_rx_upsizer.sv
// tb_hyperbus_rx_upsizer: directed and randomized bursts checked against a lane-level packing model.
module tb_hyperbus_rx_upsizer;
  localparam int PW = 32;
  localparam int AW = 64;
  localparam int R = AW / PW;
  localparam int LW = R > 1 ? $clog2(R) : 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int exp_ovr = 0;
  logic s_cmd_hs, s_rx_hs;
  logic hold_v = 1'b0;
  logic [AW+1:0] hold_b;
  logic [AW+1:0] got[$];
  logic [AW+1:0] exp_q[$];
  logic [PW-1:0] lanes[R];
  logic [PW-1:0] w[64];
  logic e[64];

  always #5 clk = ~clk;

  hyperbus_rx_upsizer_if #(.PhyWidth(PW), .AxiDataWidth(AW)) bus ();
  hyperbus_rx_upsizer #(.PhyWidth(PW), .AxiDataWidth(AW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW+1:0] beat_now();
    return {bus.r_data_o, bus.r_last_o, bus.r_error_o};
  endfunction

  function automatic logic [AW-1:0] pack_lanes();
    logic [AW-1:0] d;
    for (int l = 0; l < R; l++) d[l*PW +: PW] = lanes[l];
    return d;
  endfunction

  function automatic void clear_lanes();
    for (int l = 0; l < R; l++) lanes[l] = '0;
  endfunction

  // Expected beats: fill lanes from the start lane, cut a beat on a full row or on the
  // PHY last word, and count every word after the final beat as an overrun.
  function automatic void model(input int start, input int len, input int n);
    int lane = start;
    int beat = 0;
    bit err = 0;
    bit done = 0;
    bit lst, el;
    exp_q.delete();
    exp_ovr = 0;
`ifdef HYPERBUS_RX_ZERO_FILL_EN
    clear_lanes();
`endif
    for (int k = 0; k < n; k++) begin
      if (done) begin
        exp_ovr++;
        continue;
      end
      lanes[lane] = w[k];
      err = err | e[k];
      lst = (k == n - 1);
      if (lane == R - 1 || lst) begin
        el = (beat == len) || lst;
        exp_q.push_back({pack_lanes(), el, err | (lst && beat != len)});
`ifdef HYPERBUS_RX_ZERO_FILL_EN
        clear_lanes();
`endif
        err = 0;
        lane = 0;
        done = el;
        beat++;
      end else lane++;
    end
  endfunction

  task automatic step();
    @(negedge clk);
    s_cmd_hs = bus.cmd_valid_i && bus.cmd_ready_o;
    s_rx_hs = bus.rx_valid_i && bus.rx_ready_o;
    if (hold_v) chk("r_hold", beat_now(), hold_b);
    hold_v = bus.r_valid_o && !bus.r_ready_i;
    hold_b = beat_now();
    if (bus.r_valid_o && bus.r_ready_i) got.push_back(beat_now());
    if (bus.overrun_o) ovr_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input string tag, input int start, input int len);
    int c = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_start_i = LW'(start);
    bus.cmd_len_i = 8'(len);
    do begin
      step();
      c++;
    end while (!s_cmd_hs && c < 50);
    chk({tag, "_cmd_hs"}, s_cmd_hs, 1);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic burst(input string tag, input int start, input int len, input int n, input int err_at,
                       input int rdy_pct, input int gap_pct, input bit full_rate, input int stall);
    int i = 0;
    int t = 0;
    int c = 0;
    for (int k = 0; k < n; k++) begin
      w[k] = $urandom;
      e[k] = (k == err_at);
    end
    model(start, len, n);
    got.delete();
    ovr_cnt = 0;
    send_cmd(tag, start, len);
    while (i < n && t < 2000) begin
      bus.rx_valid_i = $urandom_range(99) >= gap_pct;
      bus.rx_data_i = w[i];
      bus.rx_last_i = (i == n - 1);
      bus.rx_error_i = e[i];
      bus.r_ready_i = t >= stall && $urandom_range(99) < rdy_pct;
      step();
      t++;
      if (s_rx_hs) i++;
    end
    if (full_rate) chk({tag, "_rate"}, t, n);
    if (stall > t) chk({tag, "_rx_ready_drop"}, bus.rx_ready_o, 0);
    bus.rx_valid_i = 1'b0;
    bus.rx_last_i = 1'b0;
    bus.rx_error_i = 1'b0;
    while (!(bus.cmd_ready_o && !bus.r_valid_o) && c < 100) begin
      bus.r_ready_i = t >= stall;
      step();
      t++;
      c++;
    end
    bus.r_ready_i = 1'b1;
    step();
    step();
    chk({tag, "_words"}, i, n);
    chk({tag, "_idle"}, bus.cmd_ready_o, 1);
    chk({tag, "_nbeats"}, got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      chk($sformatf("%s_beat%0d", tag, k), got[k], exp_q[k]);
    chk({tag, "_overrun"}, ovr_cnt, exp_ovr);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_start_i = '0;
    bus.cmd_len_i = '0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i = '0;
    bus.rx_last_i = 1'b0;
    bus.rx_error_i = 1'b0;
    bus.r_ready_i = 1'b0;
    clear_lanes();
    #12;
    chk("reset_outputs", {bus.cmd_ready_o, bus.rx_ready_o, bus.r_valid_o, bus.r_last_o, bus.r_error_o,
                          bus.overrun_o, bus.r_data_o}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_cmd_ready", bus.cmd_ready_o, 1);
    chk("reset_rx_ready", bus.rx_ready_o, 0);

    burst("t1_pack", 0, 1, 4, -1, 100, 0, 1, 0);
    burst("t2_start1", 1, 0, 1, -1, 100, 0, 0, 0);
    burst("t3_stall", 0, 1, 4, -1, 100, 0, 0, 5);
    burst("t4_early", 0, 3, 3, -1, 100, 0, 0, 0);
    burst("t5_drain", 0, 0, 4, -1, 100, 0, 0, 0);
    burst("t6_err", 0, 1, 4, 1, 100, 0, 0, 0);

    send_cmd("t6_rst", 0, 1);
    bus.rx_valid_i = 1'b1;
    bus.rx_last_i = 1'b0;
    bus.r_ready_i = 1'b0;
    bus.rx_data_i = $urandom;
    step();
    bus.rx_data_i = $urandom;
    step();
    bus.rx_valid_i = 1'b0;
    chk("t6_rst_pre_valid", bus.r_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_async", {bus.cmd_ready_o, bus.rx_ready_o, bus.r_valid_o, bus.r_last_o, bus.r_error_o,
                         bus.overrun_o, bus.r_data_o}, 0);
    hold_v = 1'b0;
    clear_lanes();
    #3 rst_n = 1'b1;
    step();
    chk("t6_rst_cmd_ready", bus.cmd_ready_o, 1);
    chk("t6_rst_rx_ready", bus.rx_ready_o, 0);

    for (int r = 0; r < 8; r++) begin
      int len = $urandom_range(3);
      int n = $urandom_range(R * (len + 1) + 3, 1);
      int ea = int'($urandom_range(n)) - 1;
      burst($sformatf("rnd%0d", r), $urandom_range(R - 1), len, n, ea, 60, 20, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
